// File: rtl/scr_arb_if.sv
// Bundles the CPU, DMA and SCRATCH_RAM signals around scr_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/DMA/RAM side.
interface scr_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/scr_arbiter.sv
// Fixed-priority CPU/DMA arbiter for the single-port scratch RAM with starvation-forced DMA grants.
// Optional macro SCR_ARB_STATS_EN adds a saturating stall_cnt output.
module scr_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input logic      clk,
  input logic      rst,
  scr_arb_if.slave bus
`ifdef SCR_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {
    NORMAL  = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  state_t            fsm;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic              gnt;
  logic              stall;
  logic              forced_ok;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  // While held in reset nothing is granted and the RAM is parked on the CPU.
  assign forced_ok = (wait_cnt == WAIT_MAX) && (fsm == NORMAL);

  always_comb begin
    gnt = 1'b0;
    if (rst) begin
      gnt = bus.dma_req & (~bus.cpu_req | forced_ok);
    end
  end

  assign stall = bus.cpu_req & gnt;

  always_comb begin
    addr_mux  = bus.cpu_addr;
    wdata_mux = bus.cpu_wdata;
    we_mux    = rst & bus.cpu_req & bus.cpu_we;
    if (gnt) begin
      addr_mux  = bus.dma_addr;
      wdata_mux = bus.dma_wdata;
      we_mux    = bus.dma_we;
    end
  end

  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;
  assign bus.ram_we     = we_mux;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_stall  = stall;
  assign bus.dma_gnt    = gnt;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;

  // HOLDOFF lasts exactly one cycle so a forced grant can never repeat back to back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm      <= NORMAL;
      wait_cnt <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= gnt & ~bus.dma_we;
      if (gnt && !bus.dma_we) begin
        rdata_q <= bus.ram_rdata;
      end

      if (gnt || !bus.dma_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (fsm)
        NORMAL:  if (stall) fsm <= HOLDOFF;
        HOLDOFF: fsm <= NORMAL;
        default: fsm <= NORMAL;
      endcase
    end
  end

`ifdef SCR_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_scr_arbiter.sv
// Directed bench for scr_arbiter with a behavioural async-read scratch RAM.
// Define SCR_ARB_STATS_EN to also exercise the stall counter.
module tb_scr_arbiter;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 10;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mem [256];
  logic              mem_loaded = 1'b0;

  scr_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SCR_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  scr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SCR_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM contents are preloaded on the first edge: address 0x20 holds 0x155, others hold their address.
  assign bus.ram_rdata = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 32'h20) ? 10'h155 : 10'(i);
      mem_loaded <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                                input logic [9:0] c_wdata, input logic d_req, input logic d_we,
                                input logic [7:0] d_addr, input logic [9:0] d_wdata);
    @(negedge clk);
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wdata;
    bus.dma_req   = d_req;
    bus.dma_we    = d_we;
    bus.dma_addr  = d_addr;
    bus.dma_wdata = d_wdata;
    #1;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

    // Reset held with both requesters active: nothing may reach the RAM.
    apply_stimulus(1'b1, 1'b1, 8'h05, 10'h011, 1'b1, 1'b1, 8'h06, 10'h022);
    check_output("rst_gnt",    32'(bus.dma_gnt),    32'(1'b0));
    check_output("rst_stall",  32'(bus.cpu_stall),  32'(1'b0));
    check_output("rst_ram_we", 32'(bus.ram_we),     32'(1'b0));
    check_output("rst_addr",   32'(bus.ram_addr),   32'(8'h05));
    check_output("rst_rvalid", 32'(bus.dma_rvalid), 32'(1'b0));
    check_output("rst_rdata",  32'(bus.dma_rdata),  32'(10'h000));
`ifdef SCR_ARB_STATS_EN
    check_output("rst_stall_cnt", 32'(stall_cnt), 32'(16'h0000));
`endif

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 8'h07, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("idle_ram_we", 32'(bus.ram_we),   32'(1'b0));
    check_output("idle_addr",   32'(bus.ram_addr), 32'(8'h07));

    // CPU-only write then read back.
    apply_stimulus(1'b1, 1'b1, 8'h10, 10'h2A5, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("cpu_ram_we", 32'(bus.ram_we),    32'(1'b1));
    check_output("cpu_addr",   32'(bus.ram_addr),  32'(8'h10));
    check_output("cpu_wdata",  32'(bus.ram_wdata), 32'(10'h2A5));
    check_output("cpu_stall",  32'(bus.cpu_stall), 32'(1'b0));
    check_output("cpu_gnt",    32'(bus.dma_gnt),   32'(1'b0));
    apply_stimulus(1'b1, 1'b0, 8'h10, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("cpu_rdata", 32'(bus.cpu_rdata), 32'(10'h2A5));

    // DMA read with idle CPU: grant now, data one cycle later, then held.
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 8'h20, 10'h000);
    check_output("dmard_gnt",   32'(bus.dma_gnt),   32'(1'b1));
    check_output("dmard_addr",  32'(bus.ram_addr),  32'(8'h20));
    check_output("dmard_we",    32'(bus.ram_we),    32'(1'b0));
    check_output("dmard_stall", 32'(bus.cpu_stall), 32'(1'b0));
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("dmard_rvalid", 32'(bus.dma_rvalid), 32'(1'b1));
    check_output("dmard_rdata",  32'(bus.dma_rdata),  32'(10'h155));
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("dmard_rvalid_pulse", 32'(bus.dma_rvalid), 32'(1'b0));
    check_output("dmard_rdata_hold",   32'(bus.dma_rdata),  32'(10'h155));

    // DMA write with idle CPU produces no rvalid; CPU reads the new word.
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b1, 8'h30, 10'h3C3);
    check_output("dmawr_gnt",   32'(bus.dma_gnt),   32'(1'b1));
    check_output("dmawr_we",    32'(bus.ram_we),    32'(1'b1));
    check_output("dmawr_wdata", 32'(bus.ram_wdata), 32'(10'h3C3));
    apply_stimulus(1'b1, 1'b0, 8'h30, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("dmawr_rvalid", 32'(bus.dma_rvalid), 32'(1'b0));
    check_output("dmawr_rdback", 32'(bus.cpu_rdata),  32'(10'h3C3));

    // Continuous contention: forced grants at cycles 4 and 9, HOLDOFF right after each.
    for (int k = 0; k <= 10; k++) begin
      apply_stimulus(1'b1, 1'b1, 8'h40, 10'h001, 1'b1, 1'b0, 8'h20, 10'h000);
      check_output($sformatf("starve_gnt_%0d", k),    32'(bus.dma_gnt),    32'((k == 4) || (k == 9)));
      check_output($sformatf("starve_stall_%0d", k),  32'(bus.cpu_stall),  32'((k == 4) || (k == 9)));
      check_output($sformatf("starve_addr_%0d", k),   32'(bus.ram_addr),
                   ((k == 4) || (k == 9)) ? 32'h20 : 32'h40);
      check_output($sformatf("starve_we_%0d", k),     32'(bus.ram_we),     32'(!((k == 4) || (k == 9))));
      check_output($sformatf("starve_rvalid_%0d", k), 32'(bus.dma_rvalid), 32'((k == 5) || (k == 10)));
    end
`ifdef SCR_ARB_STATS_EN
    check_output("stats_two", 32'(stall_cnt), 32'(16'd2));
`endif

    // Dropping the DMA request clears the starvation count.
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    apply_stimulus(1'b1, 1'b0, 8'h41, 10'h000, 1'b1, 1'b0, 8'h20, 10'h000);
    apply_stimulus(1'b1, 1'b0, 8'h41, 10'h000, 1'b1, 1'b0, 8'h20, 10'h000);
    apply_stimulus(1'b1, 1'b0, 8'h41, 10'h000, 1'b0, 1'b0, 8'h20, 10'h000);
    check_output("drop_gnt", 32'(bus.dma_gnt), 32'(1'b0));
    for (int j = 0; j <= 4; j++) begin
      apply_stimulus(1'b1, 1'b0, 8'h41, 10'h000, 1'b1, 1'b0, 8'h20, 10'h000);
      check_output($sformatf("drop_regnt_%0d", j), 32'(bus.dma_gnt), 32'(j == 4));
    end

    // Reset arriving on the edge after a read grant discards the read.
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b1, 1'b0, 8'h30, 10'h000);
    check_output("rstrd_gnt", 32'(bus.dma_gnt), 32'(1'b1));
    #2 rst = 1'b0;
    apply_stimulus(1'b1, 1'b1, 8'h50, 10'h077, 1'b1, 1'b1, 8'h51, 10'h088);
    check_output("rstrd_rvalid", 32'(bus.dma_rvalid), 32'(1'b0));
    check_output("rstrd_rdata",  32'(bus.dma_rdata),  32'(10'h000));
    check_output("rstrd_gnt_lo", 32'(bus.dma_gnt),    32'(1'b0));
    check_output("rstrd_ram_we", 32'(bus.ram_we),     32'(1'b0));
    check_output("rstrd_addr",   32'(bus.ram_addr),   32'(8'h50));
    check_output("rstrd_wait",   32'(dut.wait_cnt),   32'(0));
`ifdef SCR_ARB_STATS_EN
    check_output("rstrd_stall_cnt", 32'(stall_cnt), 32'(16'h0000));
`endif
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("post_rst_rvalid", 32'(bus.dma_rvalid), 32'(1'b0));

`ifdef SCR_ARB_STATS_EN
    // Counter preset just below full scale, then two more forced stalls.
    force dut.stall_q = 16'hFFFE;
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    release dut.stall_q;
    apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
    check_output("sat_preset", 32'(stall_cnt), 32'(16'hFFFE));
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j <= 5; j++) begin
        apply_stimulus(1'b1, 1'b0, 8'h42, 10'h000, 1'b1, 1'b0, 8'h20, 10'h000);
      end
      apply_stimulus(1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
      check_output($sformatf("sat_run_%0d", r), 32'(stall_cnt), 32'(16'hFFFF));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
